// File: rtl/reg_dbg_access_ctrl_pkg.sv
// Shared types and default sizes for the debug register-access sequencer.
package reg_dbg_access_ctrl_pkg;

    localparam int unsigned REG_ADDR_W        = 5;
    localparam int unsigned REG_DATA_W        = 32;
    localparam int unsigned HALT_TIMEOUT_DFLT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HALT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dbg_acc_state_e;

endpackage

// File: rtl/reg_dbg_access_ctrl.sv
// Sequences one debug read/write onto the regfile debug port: halt the core,
// access once the halt is acknowledged, return the response, release the halt.
module reg_dbg_access_ctrl
    import reg_dbg_access_ctrl_pkg::*;
#(
    parameter int unsigned AddrW       = REG_ADDR_W,
    parameter int unsigned DataW       = REG_DATA_W,
    parameter int unsigned HaltTimeout = HALT_TIMEOUT_DFLT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [AddrW-1:0] req_addr_i,
    input  logic [DataW-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DataW-1:0] rsp_rdata_o,
    output logic             rsp_err_o,
    output logic             halt_req_o,
    input  logic             halt_ack_i,
    input  logic             ex_we_i,
    output logic             rf_we_o,
    output logic [AddrW-1:0] rf_addr_o,
    output logic [DataW-1:0] rf_wdata_o,
    input  logic [DataW-1:0] rf_rdata_i,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(HaltTimeout + 1);

    dbg_acc_state_e   state_q, state_d;
    logic [CntW-1:0]  cnt_q;
    logic             we_q;
    logic [AddrW-1:0] addr_q;
    logic [DataW-1:0] wdata_q;
    logic [DataW-1:0] rdata_q;
    logic             err_q;
    logic             req_ready_q, rsp_valid_q, halt_req_q, busy_q;
    logic             accept, rd_capture, timeout, rf_we;

    assign accept = req_valid_i & req_ready_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state; ack beats timeout, EX write-back beats the debug access.
    always_comb begin
        state_d    = state_q;
        rf_we      = 1'b0;
        rd_capture = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = HALT;
            end
            HALT: begin
                if (halt_ack_i) begin
                    state_d = ACCESS;
                end else if (cnt_q == CntW'(HaltTimeout - 1)) begin
                    state_d = RESP;
                    timeout = 1'b1;
                end
            end
            ACCESS: begin
                if (!ex_we_i) begin
                    rf_we      = we_q && (addr_q != '0);
                    rd_capture = !we_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Halt wait counter, cleared whenever the FSM is outside HALT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               cnt_q <= '0;
        else if (state_q == HALT)  cnt_q <= cnt_q + CntW'(1);
        else                       cnt_q <= '0;
    end

    // Latched request and response payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (rd_capture) rdata_q <= rf_rdata_i;
            if (timeout)    err_q   <= 1'b1;
        end
    end

    // Handshake/status outputs registered from the next state, glitch-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            halt_req_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            halt_req_q  <= (state_d != IDLE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign halt_req_o  = halt_req_q;
    assign busy_o      = busy_q;
    assign rf_we_o     = rf_we;
    assign rf_addr_o   = addr_q;
    assign rf_wdata_o  = wdata_q;

endmodule

// File: tb/tb_reg_dbg_access_ctrl.sv
// Directed bench for reg_dbg_access_ctrl: cycle checks from the stimulus,
// response payloads checked by a scoreboard monitor.
module tb_reg_dbg_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready, halt_ack, ex_we;
    logic        req_ready_o, rsp_valid_o, rsp_err_o, halt_req_o, rf_we_o, busy_o;
    logic [31:0] rsp_rdata_o, rf_wdata_o, rf_rdata;
    logic [4:0]  rf_addr_o;
    logic        rf_init;
    logic [31:0] rf [32];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    reg_dbg_access_ctrl #(.AddrW(5), .DataW(32), .HaltTimeout(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .halt_req_o  (halt_req_o),
        .halt_ack_i  (halt_ack),
        .ex_we_i     (ex_we),
        .rf_we_o     (rf_we_o),
        .rf_addr_o   (rf_addr_o),
        .rf_wdata_o  (rf_wdata_o),
        .rf_rdata_i  (rf_rdata),
        .busy_o      (busy_o)
    );

    // Regfile model: x0 reads as zero, reg 26 preset to 1.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
            rf[26] <= 32'h1;
        end else if (rf_we_o) begin
            rf[rf_addr_o] <= rf_wdata_o;
        end
    end
    assign rf_rdata = (rf_addr_o == 5'd0) ? 32'h0 : rf[rf_addr_o];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid_o && rsp_ready) begin
            if (sb.size() == 0) begin
                check1("rsp_unexpected", rsp_valid_o, 1'b0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check32("rsp_rdata", rsp_rdata_o, e.rdata);
                check1("rsp_err", rsp_err_o, e.err);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Present a request and return at the drive point of cycle 1 after accept.
    task automatic issue(input logic we, input logic [4:0] addr, input logic [31:0] wdata);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        for (int i = 0; i < 100; i++) begin
            smp();
            if (req_ready_o) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        cyc();
        req_valid = 1'b0;
        check1("req_accept", ok, 1'b1);
    endtask

    task automatic push(input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            smp();
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        check1(name, ok, 1'b1);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit bad;
        rst_n = 1'b0; rf_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 5'd0; req_wdata = 32'h0;
        rsp_ready = 1'b0; halt_ack = 1'b0; ex_we = 1'b0;
        repeat (3) cyc();
        smp();
        check1("rst_req_ready", req_ready_o, 1'b0);
        check1("rst_rsp_valid", rsp_valid_o, 1'b0);
        check1("rst_halt_req", halt_req_o, 1'b0);
        check1("rst_rf_we", rf_we_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check32("rst_rf_addr", 32'(rf_addr_o), 32'h0);
        cyc();
        rst_n = 1'b1; rf_init = 1'b0;
        cyc();
        smp();
        check1("idle_req_ready", req_ready_o, 1'b1);
        cyc();

        // Write path with ack already high.
        halt_ack = 1'b1; rsp_ready = 1'b1;
        push(32'h0, 1'b0);
        issue(1'b1, 5'd5, 32'hDEADBEEF);
        smp();
        check1("wr_c1_halt_req", halt_req_o, 1'b1);
        check1("wr_c1_rf_we", rf_we_o, 1'b0);
        cyc(); smp();
        check1("wr_c2_rf_we", rf_we_o, 1'b1);
        check32("wr_c2_rf_addr", 32'(rf_addr_o), 32'd5);
        check32("wr_c2_rf_wdata", rf_wdata_o, 32'hDEADBEEF);
        cyc(); smp();
        check1("wr_c3_rsp_valid", rsp_valid_o, 1'b1);
        check1("wr_c3_rf_we", rf_we_o, 1'b0);
        cyc(); smp();
        check1("wr_c4_halt_req", halt_req_o, 1'b0);
        check1("wr_c4_rsp_valid", rsp_valid_o, 1'b0);
        wait_idle("wr_idle");
        push(32'hDEADBEEF, 1'b0);
        issue(1'b0, 5'd5, 32'h0);
        wait_idle("rd5_idle");

        // Read with halt ack rising four cycles after accept.
        halt_ack = 1'b0;
        push(32'h1, 1'b0);
        issue(1'b0, 5'd26, 32'h0);
        bad = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            smp();
            if (!halt_req_o || rsp_valid_o) bad = 1'b1;
            cyc();
        end
        check1("dly_halt_hold", bad, 1'b0);
        halt_ack = 1'b1;
        smp();
        check1("dly_c4_rsp_valid", rsp_valid_o, 1'b0);
        cyc(); smp();
        check1("dly_c5_rsp_valid", rsp_valid_o, 1'b0);
        check1("dly_c5_halt_req", halt_req_o, 1'b1);
        cyc(); smp();
        check1("dly_c6_rsp_valid", rsp_valid_o, 1'b1);
        check32("dly_c6_rdata", rsp_rdata_o, 32'h1);
        wait_idle("dly_idle");

        // Halt timeout on a read of a non-zero register.
        halt_ack = 1'b0;
        push(32'h0, 1'b1);
        issue(1'b0, 5'd26, 32'h0);
        bad = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            smp();
            if (rsp_valid_o || rf_we_o || !halt_req_o) bad = 1'b1;
            cyc();
        end
        check1("to_wait", bad, 1'b0);
        smp();
        check1("to_c17_rsp_valid", rsp_valid_o, 1'b1);
        check1("to_c17_err", rsp_err_o, 1'b1);
        check32("to_c17_rdata", rsp_rdata_o, 32'h0);
        cyc(); smp();
        check1("to_c18_halt_req", halt_req_o, 1'b0);
        wait_idle("to_idle");

        // EX write-back collides for two ACCESS cycles.
        halt_ack = 1'b1;
        push(32'h0, 1'b0);
        issue(1'b1, 5'd3, 32'hA5A50003);
        cyc();
        ex_we = 1'b1;
        smp();
        check1("ex_c2_rf_we", rf_we_o, 1'b0);
        cyc(); smp();
        check1("ex_c3_rf_we", rf_we_o, 1'b0);
        check1("ex_c3_rsp_valid", rsp_valid_o, 1'b0);
        cyc();
        ex_we = 1'b0;
        smp();
        check1("ex_c4_rf_we", rf_we_o, 1'b1);
        check32("ex_c4_rf_addr", 32'(rf_addr_o), 32'd3);
        cyc(); smp();
        check1("ex_c5_rsp_valid", rsp_valid_o, 1'b1);
        check1("ex_c5_rf_we", rf_we_o, 1'b0);
        wait_idle("ex_idle");
        push(32'hA5A50003, 1'b0);
        issue(1'b0, 5'd3, 32'h0);
        wait_idle("rd3_idle");

        // Response backpressure, then writes/reads of address 0.
        rsp_ready = 1'b0;
        push(32'h1, 1'b0);
        issue(1'b0, 5'd26, 32'h0);
        cyc(); cyc();
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            smp();
            if (!rsp_valid_o || rsp_rdata_o !== 32'h1 || req_ready_o || !halt_req_o) bad = 1'b1;
            cyc();
        end
        check1("bp_stable", bad, 1'b0);
        rsp_ready = 1'b1;
        wait_idle("bp_idle");
        push(32'h0, 1'b0);
        issue(1'b1, 5'd0, 32'hFFFFFFFF);
        cyc(); smp();
        check1("a0_c2_rf_we", rf_we_o, 1'b0);
        cyc(); smp();
        check1("a0_c3_rsp_valid", rsp_valid_o, 1'b1);
        check1("a0_c3_err", rsp_err_o, 1'b0);
        wait_idle("a0_idle");
        push(32'h0, 1'b0);
        issue(1'b0, 5'd0, 32'h0);
        wait_idle("a0rd_idle");

        // Asynchronous reset while a write is being driven in ACCESS.
        issue(1'b1, 5'd9, 32'h99999999);
        cyc(); smp();
        check1("ar_access_rf_we", rf_we_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1("ar_halt_req", halt_req_o, 1'b0);
        check1("ar_rf_we", rf_we_o, 1'b0);
        check1("ar_rsp_valid", rsp_valid_o, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc(); smp();
        check1("ar_req_ready", req_ready_o, 1'b1);
        check1("ar_busy", busy_o, 1'b0);
        cyc();
        push(32'h0, 1'b0);
        issue(1'b0, 5'd9, 32'h0);
        wait_idle("ar_rd_idle");

        repeat (2) cyc();
        check32("sb_drain", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_dbg_access_ctrl.md
Name: reg_dbg_access_ctrl

Overview:
- Sequences debug (JTAG) read/write requests onto the register file's debug port.
- For each request: halts the core pipeline, performs one register access once the core acknowledges the halt, returns the result over a valid/ready response channel, then releases the halt.
- Sits between the JTAG DM and the register file's jtag_we/jtag_addr/jtag_data port.
- Guarantees a debug access never collides with an EX write-back.

Parameters:
- AddrW, 5, register address width (matches RegAddrBus).
- DataW, 32, register data width (matches RegBus).
- HaltTimeout, 16, maximum HALT-state cycles waiting for halt_ack_i before the request is failed; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  debug request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  AddrW  register index
- req_wdata_i  in  DataW  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DataW  read data (0 for writes and errors)
- rsp_err_o  out  1  1 = halt timeout, access not performed
- halt_req_o  out  1  request core pipeline halt
- halt_ack_i  in  1  core halted and pipeline drained
- ex_we_i  in  1  EX write-back active this cycle
- rf_we_o  out  1  to regfile jtag_we_i
- rf_addr_o  out  AddrW  to regfile jtag_addr_i
- rf_wdata_o  out  DataW  to regfile jtag_data_i
- rf_rdata_i  in  DataW  from regfile jtag_data_o
- busy_o  out  1  state != IDLE

Behaviour:
- Reset state: IDLE. All outputs 0, latched request 0, timeout counter 0.
- Asserting reset mid-operation aborts the transaction at once: no write, no response, halt_req_o drops asynchronously.
- Request capture: req_ready_o = 1 only in IDLE. On valid&ready, latch we/addr/wdata and go to HALT.
- HALT:
  - halt_req_o = 1, counter increments each cycle.
  - halt_ack_i = 1 sampled -> ACCESS.
  - Counter reaches HaltTimeout-1 without ack -> RESP with err = 1, rdata = 0.
  - Ack in the same cycle as timeout: ack wins.
- ACCESS:
  - halt_req_o = 1; rf_addr_o / rf_wdata_o = latched values.
  - If ex_we_i = 1: rf_we_o = 0, stay in ACCESS and retry next cycle (EX has regfile write priority).
  - Otherwise, write: rf_we_o = 1 for exactly one cycle, then RESP.
  - Otherwise, read: rf_we_o = 0; capture rf_rdata_i into the rsp_rdata register at the clock edge, then RESP.
- RESP:
  - rsp_valid_o = 1, halt_req_o = 1; rsp data/err stable until handshake.
  - On rsp_ready_i -> IDLE; halt_req_o = 0 from the next cycle.
- Address 0: a write asserts no rf_we_o and completes normally with err = 0. A read returns 0 because the regfile forces 0.
- rf_addr_o drives the latched address in all states; rf_we_o is 0 outside ACCESS.
- Latency with halt_ack_i already high: accept at cycle 0, HALT at 1, ACCESS at 2, rsp_valid_o at 3.
- Each ex_we_i collision adds 1 cycle.
- Timeout path: rsp_valid_o asserts HaltTimeout+1 cycles after accept.
- No request queueing. A new request waits in IDLE for req_ready_o.
- halt_req_o is registered and glitch-free.

Decomposition:
- Shared package (tinyriscv_pkg): enum dbg_acc_state_e {IDLE, HALT, ACCESS, RESP} and the HaltTimeout default constant.
- Reuse existing RegAddrBus/RegBus/WriteEnable.
- Single module; no sub-module. The timeout counter is a small inline always_ff with width $clog2(HaltTimeout+1).

Test Plan:
- Write path: halt_ack_i tied 1, write addr 5 data 0xDEADBEEF. rf_we_o high exactly at cycle 2 with addr 5; rsp_valid_o at cycle 3, err = 0. A subsequent read of 5 returns 0xDEADBEEF.
- Read with delayed halt: halt_ack_i rises 4 cycles after accept, read addr 26 holding 0x1. halt_req_o is high from cycle 1; rsp_rdata_o = 0x1 at cycle 6.
- Halt timeout: HaltTimeout = 16, halt_ack_i held 0. rsp_valid_o at cycle 17 with err = 1 and rdata = 0; rf_we_o never asserted; halt_req_o low the cycle after rsp handshake.
- EX collision: ex_we_i high for 2 cycles during ACCESS of a write to addr 3. rf_we_o stays 0 for those cycles, then pulses once; response 2 cycles later than nominal.
- Response backpressure and addr 0: rsp_ready_i low for 5 cycles. rsp_valid_o/rdata stay stable, req_ready_o stays 0, halt_req_o stays 1. Then a write to addr 0 gives no rf_we_o pulse and err = 0.
- Async reset in ACCESS: rst_ni low mid-cycle. halt_req_o, rf_we_o and rsp_valid_o go 0 immediately; after release, state is IDLE and req_ready_o = 1.
